// File: rtl/psram_bus_arbiter_if.sv
// Request/response bundle between the CPU and VIC requesters, the arbiter and memCtrl.
// The arbiter takes the slave view; the requesters and the memory side take the master view.
interface psram_bus_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  logic        vic_req;
  logic [15:0] vic_addr;
  logic [7:0]  vic_rdata;
  logic        vic_done;
  logic        timeout_err;
  logic        mem_ce;
  logic        mem_write;
  logic [5:0]  mem_bank;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_busy;
  logic        mem_ready;
  logic [7:0]  mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vic_req, vic_addr,
    input  mem_busy, mem_ready, mem_rdata,
    output cpu_rdata, cpu_done, vic_rdata, vic_done, timeout_err,
    output mem_ce, mem_write, mem_bank, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vic_req, vic_addr,
    output mem_busy, mem_ready, mem_rdata,
    input  cpu_rdata, cpu_done, vic_rdata, vic_done, timeout_err,
    input  mem_ce, mem_write, mem_bank, mem_addr, mem_wdata
  );
endinterface

// File: rtl/psram_bus_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller between the 6510 CPU and VIC fetch ports.
// One transaction in flight: IDLE -> ISSUE (CE pulse) -> WAIT (busy/ready or timeout) -> DONE.
module psram_bus_arbiter #(
  parameter logic [5:0] CPU_BANK = 6'd0,
  parameter logic [5:0] VIC_BANK = 6'd0,
  parameter logic [7:0] TIMEOUT  = 8'd255
) (
  input logic                clkPhi0,
  input logic                reset,
  psram_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      r_state;
  logic        r_win_vic;
  logic        r_last_vic;
  logic        r_we;
  logic        r_abort;
  logic [7:0]  r_timer;
  logic [7:0]  r_rbuf;
  logic        r_ce;
  logic        r_write;
  logic [5:0]  r_bank;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_cpu_done;
  logic        r_vic_done;
  logic [7:0]  r_cpu_rdata;
  logic [7:0]  r_vic_rdata;
  logic        r_to;

  logic w_grant;
  logic w_pick_vic;
  logic w_exit;
  logic w_expire;

  assign w_grant    = (bus.cpu_req | bus.vic_req) & ~bus.mem_busy;
  // On a tie the requester that did not win last time goes next.
  assign w_pick_vic = bus.vic_req & (~bus.cpu_req | ~r_last_vic);
  assign w_exit     = r_we ? ~bus.mem_busy : bus.mem_ready;
  assign w_expire   = (r_timer == (TIMEOUT - 8'd1));

  always_ff @(posedge clkPhi0 or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_win_vic   <= 1'b0;
      r_last_vic  <= 1'b0;
      r_we        <= 1'b0;
      r_abort     <= 1'b0;
      r_timer     <= 8'd0;
      r_rbuf      <= 8'd0;
      r_ce        <= 1'b0;
      r_write     <= 1'b0;
      r_bank      <= 6'd0;
      r_addr      <= 16'd0;
      r_wdata     <= 8'd0;
      r_cpu_done  <= 1'b0;
      r_vic_done  <= 1'b0;
      r_cpu_rdata <= 8'd0;
      r_vic_rdata <= 8'd0;
      r_to        <= 1'b0;
    end else begin
      r_cpu_done <= 1'b0;
      r_vic_done <= 1'b0;
      r_to       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_win_vic <= w_pick_vic;
            r_ce      <= 1'b1;
            r_state   <= ISSUE;
            if (w_pick_vic) begin
              r_addr  <= bus.vic_addr;
              r_bank  <= VIC_BANK;
              r_wdata <= 8'd0;
              r_we    <= 1'b0;
              r_write <= 1'b0;
            end else begin
              r_addr  <= bus.cpu_addr;
              r_bank  <= CPU_BANK;
              r_wdata <= bus.cpu_wdata;
              r_we    <= bus.cpu_we;
              r_write <= bus.cpu_we;
            end
          end
        end
        ISSUE: begin
          r_ce    <= 1'b0;
          r_timer <= 8'd0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_timer <= r_timer + 8'd1;
          // A real exit on the last allowed cycle still wins over the abort.
          if (w_exit) begin
            r_rbuf  <= bus.mem_rdata;
            r_abort <= 1'b0;
            r_state <= DONE;
          end else if (w_expire) begin
            r_rbuf  <= 8'hFF;
            r_abort <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_write    <= 1'b0;
          r_last_vic <= r_win_vic;
          r_to       <= r_abort;
          r_state    <= IDLE;
          if (r_win_vic) begin
            r_vic_done  <= 1'b1;
            r_vic_rdata <= r_rbuf;
          end else begin
            r_cpu_done <= 1'b1;
            // Completed writes leave the last read value in place.
            if (!r_we || r_abort) r_cpu_rdata <= r_rbuf;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_ce      = r_ce;
  assign bus.mem_write   = r_write;
  assign bus.mem_bank    = r_bank;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.cpu_done    = r_cpu_done;
  assign bus.cpu_rdata   = r_cpu_rdata;
  assign bus.vic_done    = r_vic_done;
  assign bus.vic_rdata   = r_vic_rdata;
  assign bus.timeout_err = r_to;

endmodule

// File: tb/tb_psram_bus_arbiter.sv
// Bench for psram_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (winner rule, latency 3+n, rdata/timeout outcome).
module tb_psram_bus_arbiter;
  localparam logic [7:0] TO = 8'd8;
  localparam logic [5:0] CB = 6'd5;
  localparam logic [5:0] VB = 6'd42;

  logic clkPhi0 = 1'b0;
  logic reset   = 1'b0;
  always #5 clkPhi0 = ~clkPhi0;

  psram_bus_arbiter_if bus();

  psram_bus_arbiter #(.CPU_BANK(CB), .VIC_BANK(VB), .TIMEOUT(TO)) dut (
    .clkPhi0(clkPhi0),
    .reset  (reset),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_crd = 8'd0;
  logic [7:0] exp_vrd = 8'd0;
  logic       exp_last_vic = 1'b0;

  // Memory controller stand-in: counts WAIT samples from the CE pulse and ends the
  // access on sample resp_d (ready for reads, busy falling for writes).
  int         phase = -1;
  int         resp_d = 1;
  logic [7:0] resp_data = 8'd0;
  logic       r_busy = 1'b0;
  logic       force_busy = 1'b0;
  assign bus.mem_busy = r_busy | force_busy;

  always @(negedge clkPhi0) begin
    if (!reset) phase = -1;
    else if (bus.mem_ce) phase = 0;
    else if (phase >= 0 && phase < 1000) phase++;
    r_busy        = (phase >= 1) && (phase < resp_d) && (phase <= int'(TO));
    bus.mem_ready = (phase >= 1) && (phase == resp_d) && !bus.mem_write;
    bus.mem_rdata = (phase == resp_d) ? resp_data : 8'($urandom);
  end

  typedef struct {
    bit got, fin, ce1, stable, pulse1, we, cd, vd, to;
    logic [15:0] addr;
    logic [5:0]  bank;
    logic [7:0]  wd, crd, vrd;
    int lat;
  } obs_t;

  function automatic int exp_lat(int d);
    return 3 + ((d > int'(TO)) ? int'(TO) : d);
  endfunction

  // mode: 0 hold reqs, 1 drop finished req at done, 2 drop winner right after grant, 3 drop all at done
  task automatic observe(input int mode, output obs_t o);
    int g = 0;
    o.got = 0; o.fin = 0; o.ce1 = 0; o.stable = 1; o.pulse1 = 0; o.we = 0;
    o.cd = 0; o.vd = 0; o.to = 0; o.addr = 0; o.bank = 0; o.wd = 0; o.crd = 0; o.vrd = 0; o.lat = 0;
    while (!bus.mem_ce && g < 400) begin @(negedge clkPhi0); g++; end
    if (!bus.mem_ce) return;
    o.got = 1; o.we = bus.mem_write; o.addr = bus.mem_addr; o.bank = bus.mem_bank; o.wd = bus.mem_wdata;
    if (mode == 2) begin
      if (bus.mem_bank == VB) bus.vic_req = 1'b0; else bus.cpu_req = 1'b0;
    end
    @(negedge clkPhi0); g = 1;
    o.ce1 = !bus.mem_ce;
    while (!(bus.cpu_done || bus.vic_done) && g < 400) begin
      if (bus.mem_addr !== o.addr || bus.mem_bank !== o.bank || bus.mem_wdata !== o.wd) o.stable = 0;
      @(negedge clkPhi0); g++;
    end
    if (!(bus.cpu_done || bus.vic_done)) return;
    if (bus.mem_addr !== o.addr || bus.mem_bank !== o.bank || bus.mem_wdata !== o.wd) o.stable = 0;
    o.fin = 1; o.lat = g + 1; o.cd = bus.cpu_done; o.vd = bus.vic_done; o.to = bus.timeout_err;
    o.crd = bus.cpu_rdata; o.vrd = bus.vic_rdata;
    if (mode == 1) begin
      if (o.cd) bus.cpu_req = 1'b0;
      if (o.vd) bus.vic_req = 1'b0;
    end else if (mode == 3) begin
      bus.cpu_req = 1'b0; bus.vic_req = 1'b0;
    end
    @(negedge clkPhi0);
    o.pulse1 = !bus.cpu_done && !bus.vic_done;
  endtask

  task automatic do_reset();
    bus.cpu_req = 0; bus.vic_req = 0; force_busy = 0;
    reset = 1'b0;
    repeat (3) @(negedge clkPhi0);
    reset = 1'b1;
    @(negedge clkPhi0);
    exp_crd = 0; exp_vrd = 0; exp_last_vic = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clkPhi0);
    n_chk++; if (bus.mem_ce !== 1'b0 || bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ctl: got ce=%b we=%b want 0 0", bus.mem_ce, bus.mem_write); end
    n_chk++; if (bus.cpu_done !== 1'b0 || bus.vic_done !== 1'b0 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b%b%b want 000", bus.cpu_done, bus.vic_done, bus.timeout_err); end
    n_chk++; if ({bus.cpu_rdata, bus.vic_rdata} !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 00 00", bus.cpu_rdata, bus.vic_rdata); end
    n_chk++; if ({bus.mem_addr, bus.mem_bank, bus.mem_wdata} !== 30'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h %h %h want 0", bus.mem_addr, bus.mem_bank, bus.mem_wdata); end
    reset = 1'b1;
    @(negedge clkPhi0);
  endtask

  task automatic test_cpu_write();
    obs_t o;
    bus.cpu_we = 1; bus.cpu_addr = 16'd49152; bus.cpu_wdata = 8'd121; resp_d = 3; bus.cpu_req = 1;
    observe(1, o);
    n_chk++; if ({o.got, o.fin, o.ce1, o.pulse1, o.stable} !== 5'b11111) begin n_fail++; $display("FAIL wr_handshake: got %b want 11111", {o.got, o.fin, o.ce1, o.pulse1, o.stable}); end
    n_chk++; if (o.we !== 1'b1 || o.addr !== 16'd49152 || o.wd !== 8'd121 || o.bank !== CB) begin n_fail++; $display("FAIL wr_bus: got we=%b a=%0d d=%0d b=%0d want 1 49152 121 %0d", o.we, o.addr, o.wd, o.bank, CB); end
    n_chk++; if (o.lat != 6) begin n_fail++; $display("FAIL wr_latency: got %0d want 6", o.lat); end
    n_chk++; if (o.cd !== 1'b1 || o.vd !== 1'b0 || o.to !== 1'b0) begin n_fail++; $display("FAIL wr_done: got cd=%b vd=%b to=%b want 1 0 0", o.cd, o.vd, o.to); end
    n_chk++; if (o.crd !== exp_crd) begin n_fail++; $display("FAIL wr_rdata_kept: got %h want %h", o.crd, exp_crd); end
    exp_last_vic = 0;
  endtask

  task automatic test_cpu_read();
    obs_t o;
    bus.cpu_we = 0; bus.cpu_addr = 16'd49152; resp_d = 2; resp_data = 8'd121; bus.cpu_req = 1;
    observe(1, o);
    n_chk++; if ({o.fin, o.ce1, o.pulse1} !== 3'b111 || o.we !== 1'b0) begin n_fail++; $display("FAIL rd_handshake: got %b we=%b want 111 0", {o.fin, o.ce1, o.pulse1}, o.we); end
    n_chk++; if (o.lat != 5) begin n_fail++; $display("FAIL rd_latency: got %0d want 5", o.lat); end
    n_chk++; if (o.crd !== 8'd121 || o.to !== 1'b0) begin n_fail++; $display("FAIL rd_data: got %0d to=%b want 121 0", o.crd, o.to); end
    exp_crd = 8'd121;
  endtask

  task automatic test_alternation();
    obs_t o;
    logic want_vic;
    do_reset();
    bus.cpu_we = 0; bus.cpu_addr = 16'h1234; bus.vic_addr = 16'hABCD;
    bus.cpu_req = 1; bus.vic_req = 1;
    want_vic = 1;
    for (int k = 0; k < 4; k++) begin
      resp_d = int'($urandom_range(1, 4)); resp_data = 8'($urandom);
      observe((k == 3) ? 3 : 0, o);
      n_chk++; if (o.fin !== 1'b1 || o.vd !== want_vic || o.cd !== !want_vic) begin n_fail++; $display("FAIL alt_order[%0d]: got vd=%b cd=%b want vd=%b", k, o.vd, o.cd, want_vic); end
      n_chk++; if (o.lat != exp_lat(resp_d) || o.addr !== (want_vic ? 16'hABCD : 16'h1234)) begin n_fail++; $display("FAIL alt_txn[%0d]: got lat=%0d a=%h want %0d", k, o.lat, o.addr, exp_lat(resp_d)); end
      if (want_vic) exp_vrd = resp_data; else exp_crd = resp_data;
      n_chk++; if (o.crd !== exp_crd || o.vrd !== exp_vrd) begin n_fail++; $display("FAIL alt_rdata[%0d]: got c=%h v=%h want c=%h v=%h", k, o.crd, o.vrd, exp_crd, exp_vrd); end
      want_vic = !want_vic;
    end
    exp_last_vic = 0;
  endtask

  task automatic test_timeout();
    obs_t o;
    bus.cpu_we = 0; bus.cpu_addr = 16'h0042; resp_d = 50; bus.cpu_req = 1;
    observe(1, o);
    n_chk++; if (o.fin !== 1'b1 || o.lat != 3 + int'(TO)) begin n_fail++; $display("FAIL to_latency: got fin=%b lat=%0d want 1 %0d", o.fin, o.lat, 3 + int'(TO)); end
    n_chk++; if (o.crd !== 8'hFF || o.to !== 1'b1) begin n_fail++; $display("FAIL to_result: got %h to=%b want ff 1", o.crd, o.to); end
    n_chk++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", bus.timeout_err); end
    exp_crd = 8'hFF; exp_last_vic = 0;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int g = 0;
    int seen = 0;
    bus.cpu_we = 0; bus.cpu_addr = 16'h7777; resp_d = 20; bus.cpu_req = 1;
    while (!bus.mem_ce && g < 50) begin @(negedge clkPhi0); g++; end
    n_chk++; if (bus.mem_ce !== 1'b1) begin n_fail++; $display("FAIL rmid_grant: got ce=%b want 1", bus.mem_ce); end
    repeat (3) @(negedge clkPhi0);
    #2 reset = 1'b0; bus.cpu_req = 0;
    #1;
    n_chk++; if ({bus.mem_ce, bus.mem_write, bus.cpu_done, bus.vic_done, bus.timeout_err} !== 5'b0) begin n_fail++; $display("FAIL rmid_outputs: got %b want 00000", {bus.mem_ce, bus.mem_write, bus.cpu_done, bus.vic_done, bus.timeout_err}); end
    n_chk++; if (bus.mem_addr !== 16'h0 || bus.cpu_rdata !== 8'h0) begin n_fail++; $display("FAIL rmid_bus: got a=%h rd=%h want 0 0", bus.mem_addr, bus.cpu_rdata); end
    repeat (2) @(negedge clkPhi0);
    reset = 1'b1;
    exp_crd = 0; exp_vrd = 0; exp_last_vic = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clkPhi0);
      if (bus.mem_ce || bus.cpu_done || bus.vic_done) seen++;
    end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL rmid_idle: got %0d active cycles want 0", seen); end
    resp_d = 1; resp_data = 8'($urandom); bus.cpu_req = 1;
    observe(1, o);
    n_chk++; if (o.fin !== 1'b1 || o.lat != 4 || o.crd !== resp_data || o.to !== 1'b0) begin n_fail++; $display("FAIL rmid_next_read: got lat=%0d rd=%h want 4 %h", o.lat, o.crd, resp_data); end
    exp_crd = resp_data;
  endtask

  task automatic test_busy_hold();
    obs_t o;
    int seen = 0;
    force_busy = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0F0F; resp_d = 1; resp_data = 8'h5A; bus.cpu_req = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clkPhi0);
      if (bus.mem_ce) seen++;
    end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL busy_no_ce: got %0d ce cycles want 0", seen); end
    force_busy = 0;
    @(negedge clkPhi0);
    n_chk++; if (bus.mem_ce !== 1'b1) begin n_fail++; $display("FAIL busy_grant_delay: got ce=%b want 1", bus.mem_ce); end
    observe(1, o);
    n_chk++; if (o.fin !== 1'b1 || o.lat != 4 || o.crd !== 8'h5A) begin n_fail++; $display("FAIL busy_read: got lat=%0d rd=%h want 4 5a", o.lat, o.crd); end
    exp_crd = 8'h5A; exp_last_vic = 0;
  endtask

  task automatic test_random();
    obs_t o;
    logic cp, vp, win_vic, we, tmo;
    logic [15:0] ca, va;
    logic [7:0] cw;
    int d, ntx;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) @(negedge clkPhi0);
      {vp, cp} = 2'($urandom_range(1, 3));
      we = 1'($urandom); ca = 16'($urandom); va = 16'($urandom); cw = 8'($urandom);
      bus.cpu_we = we; bus.cpu_addr = ca; bus.cpu_wdata = cw; bus.vic_addr = va;
      bus.cpu_req = cp; bus.vic_req = vp;
      ntx = int'(cp) + int'(vp);
      for (int t = 0; t < ntx; t++) begin
        win_vic = vp && (!cp || !exp_last_vic);
        d = int'($urandom_range(1, 10)); resp_d = d; resp_data = 8'($urandom);
        observe(($urandom_range(0, 3) == 0) ? 2 : 1, o);
        tmo = (d > int'(TO));
        n_chk++; if ({o.fin, o.ce1, o.pulse1, o.stable} !== 4'b1111) begin n_fail++; $display("FAIL rnd_handshake[%0d.%0d]: got %b want 1111", it, t, {o.fin, o.ce1, o.pulse1, o.stable}); end
        n_chk++; if (o.vd !== win_vic || o.cd !== !win_vic) begin n_fail++; $display("FAIL rnd_winner[%0d.%0d]: got vd=%b cd=%b want vd=%b", it, t, o.vd, o.cd, win_vic); end
        n_chk++; if (o.addr !== (win_vic ? va : ca) || o.bank !== (win_vic ? VB : CB) || o.we !== (!win_vic && we)) begin n_fail++; $display("FAIL rnd_bus[%0d.%0d]: got a=%h b=%0d we=%b", it, t, o.addr, o.bank, o.we); end
        n_chk++; if (!win_vic && we && o.wd !== cw) begin n_fail++; $display("FAIL rnd_wdata[%0d.%0d]: got %h want %h", it, t, o.wd, cw); end
        n_chk++; if (o.lat != exp_lat(d) || o.to !== tmo) begin n_fail++; $display("FAIL rnd_timing[%0d.%0d]: got lat=%0d to=%b want %0d %b", it, t, o.lat, o.to, exp_lat(d), tmo); end
        if (win_vic) exp_vrd = tmo ? 8'hFF : resp_data;
        else if (!we || tmo) exp_crd = tmo ? 8'hFF : resp_data;
        n_chk++; if (o.crd !== exp_crd || o.vrd !== exp_vrd) begin n_fail++; $display("FAIL rnd_rdata[%0d.%0d]: got c=%h v=%h want c=%h v=%h", it, t, o.crd, o.vrd, exp_crd, exp_vrd); end
        exp_last_vic = win_vic;
        if (win_vic) vp = 0; else cp = 0;
      end
    end
  endtask

  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.vic_req = 0; bus.vic_addr = 0;
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_alternation();
    test_timeout();
    test_reset_mid();
    test_busy_hold();
    test_random();
    repeat (2) @(negedge clkPhi0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
